// File: rtl/md_pkg.sv
// Shared constants and helpers for the ping-pong buffer.
package md_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    function automatic logic [1:0] count_full(input logic [1:0] flags);
        return {1'b0, flags[0]} + {1'b0, flags[1]};
    endfunction

endpackage

// File: rtl/rf_2p.sv
// Two-port register file: one write port and one registered read port, both with active-low enables.
module rf_2p #(
    parameter int Addr_Width = 4,
    parameter int Word_Width = 32
) (
    input  logic                  clk,
    input  logic                  wr_n,
    input  logic [Addr_Width-1:0] wr_addr,
    input  logic [Word_Width-1:0] wr_data,
    input  logic                  rd_n,
    input  logic [Addr_Width-1:0] rd_addr,
    output logic [Word_Width-1:0] rd_data
);

    logic [Word_Width-1:0] mem [2**Addr_Width];

    // Storage array and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (!wr_n) begin
            mem[wr_addr] <= wr_data;
        end
        if (!rd_n) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/md_pingpong_ram.sv
// Double-buffered RAM: a producer fills one bank while a consumer drains the other,
// with ownership handed over by wr_done / rd_done pulses.
module md_pingpong_ram
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [1:0]            bank_cnt
);

    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] full_r;
    logic       rd_valid_r;
    logic       rd_sel_r;

    logic       wr_free_s;
    logic       rd_avail_s;
    logic       wr_acc_s;
    logic       rd_acc_s;
    logic       wr_fin_s;
    logic       rd_fin_s;
    logic [1:0] set_mask_s;
    logic [1:0] clr_mask_s;
    logic [1:0] full_nxt_s;
    logic [1:0] wr_n_s;
    logic [1:0] rd_n_s;
    logic [DATA_WIDTH-1:0] bank_q_s [2];

    assign wr_free_s  = ~full_r[wr_ptr_r];
    assign rd_avail_s = full_r[rd_ptr_r];

    // Outputs are forced to their idle values while reset is held.
    assign wr_ready = rst | wr_free_s;
    assign rd_ready = ~rst & rd_avail_s;
    assign bank_cnt = rst ? 2'd0 : count_full(full_r);
    assign rd_valid = rd_valid_r;
    assign rd_data  = (rd_valid_r && !rst) ? bank_q_s[rd_sel_r] : {DATA_WIDTH{1'b0}};

    assign wr_acc_s = ~rst & wr_en   & wr_free_s;
    assign rd_acc_s = ~rst & rd_en   & rd_avail_s;
    assign wr_fin_s = ~rst & wr_done & wr_free_s;
    assign rd_fin_s = ~rst & rd_done & rd_avail_s;

    // Write and read sides can only complete on different banks, so the masks never collide.
    assign set_mask_s = wr_fin_s ? (2'b01 << wr_ptr_r) : 2'b00;
    assign clr_mask_s = rd_fin_s ? (2'b01 << rd_ptr_r) : 2'b00;
    assign full_nxt_s = (full_r | set_mask_s) & ~clr_mask_s;

    // Bank ownership pointers, full flags and read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            full_r     <= 2'b00;
            rd_valid_r <= 1'b0;
            rd_sel_r   <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r ^ wr_fin_s;
            rd_ptr_r   <= rd_ptr_r ^ rd_fin_s;
            full_r     <= full_nxt_s;
            rd_valid_r <= rd_acc_s;
            rd_sel_r   <= rd_acc_s ? rd_ptr_r : rd_sel_r;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_n_s[b] = ~(wr_acc_s & (wr_ptr_r == 1'(b)));
        assign rd_n_s[b] = ~(rd_acc_s & (rd_ptr_r == 1'(b)));

        rf_2p #(
            .Addr_Width (ADDR_WIDTH),
            .Word_Width (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .wr_n    (wr_n_s[b]),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_n    (rd_n_s[b]),
            .rd_addr (rd_addr),
            .rd_data (bank_q_s[b])
        );
    end

endmodule

// File: doc/md_pingpong_ram.md
MD_PINGPONG_RAM -- requirements
Module: md_pingpong_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, per-bank address width; depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write strobe into the current write bank.
REQ-006 SHALL have port wr_addr  input  ADDR_WIDTH  write word address.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-008 SHALL have port wr_done  input  1  pulse; the current write bank is complete.
REQ-009 SHALL have port wr_ready  output  1  the current write bank is free.
REQ-010 SHALL have port rd_en  input  1  read strobe from the current read bank.
REQ-011 SHALL have port rd_addr  input  ADDR_WIDTH  read word address.
REQ-012 SHALL have port rd_done  input  1  pulse; release the current read bank.
REQ-013 SHALL have port rd_ready  output  1  the current read bank holds a complete block.
REQ-014 SHALL have port rd_data  output  DATA_WIDTH  read data.
REQ-015 SHALL have port rd_valid  output  1  rd_data is valid this cycle.
REQ-016 SHALL have port bank_cnt  output  2  number of full banks (0..2).

Function
REQ-017 SHALL hold two banks and the 1-bit pointers wr_ptr, rd_ptr, plus the flags full[1:0].
REQ-018 SHALL drive wr_ready = ~full[wr_ptr] and rd_ready = full[rd_ptr], both combinationally from registers.
REQ-019 SHALL write wr_data at wr_addr of bank wr_ptr when wr_en & wr_ready; wr_en while ~wr_ready SHALL NOT modify any bank.
REQ-020 SHALL, on wr_done & wr_ready, set full[wr_ptr] and toggle wr_ptr at the next edge; wr_done while ~wr_ready SHALL be ignored.
REQ-021 SHALL, when wr_en and wr_done are in the same cycle, perform the write into the old bank before the bank is marked full.
REQ-022 SHALL, on rd_en & rd_ready, read bank rd_ptr at rd_addr, with rd_valid=1 and rd_data exactly one cycle later; rd_en while ~rd_ready SHALL produce no rd_valid.
REQ-023 SHALL drive rd_data to all-zero whenever rd_valid=0.
REQ-024 SHALL, on rd_done & rd_ready, clear full[rd_ptr] and toggle rd_ptr at the next edge; rd_done while ~rd_ready SHALL be ignored.
REQ-025 SHALL, when rd_en and rd_done are in the same cycle, return the read from the released bank with normal 1-cycle latency.
REQ-026 SHALL honour simultaneous accepted wr_done and rd_done in the same cycle, each acting on its own bank.
REQ-027 SHALL support writes and reads in the same cycle, because they always target different banks when both are accepted.
REQ-028 SHALL drive bank_cnt = full[0] + full[1], registered-consistent with the flags.
REQ-029 SHALL give the read data zero bypass from write data: a bank becomes readable only after its wr_done.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, full=2'b00, rd_valid=0.
REQ-031 SHALL, while rst=1, set rd_data=0, wr_ready=1, rd_ready=0, and bank_cnt=0.
REQ-032 SHALL, when rst is asserted mid-operation, discard all pending blocks by clearing the flags, leave the RAM contents uncleared, and discard any read in flight (no rd_valid the cycle after reset).

Structure
REQ-033 SHALL place the default DATA_WIDTH/ADDR_WIDTH constants in shared package md_pkg.
REQ-034 SHALL implement each bank as one instance of the existing two-port register file rf_2p (Addr_Width=ADDR_WIDTH, Word_Width=DATA_WIDTH), active-low enables; two instances, no other sub-module.

Verification
REQ-035 SHALL cover: write 16 words (data=addr*3) to bank0, wr_done -> bank_cnt=1, rd_ready=1; read addr 5 -> rd_valid next cycle, rd_data=15.
REQ-036 SHALL cover: fill both banks without rd_done -> wr_ready=0, bank_cnt=2; a third wr_en at addr 0 with 0xDEAD -> bank0 addr 0 is unchanged on readback.
REQ-037 SHALL cover: rd_en at addr 2 together with rd_done -> rd_data=bank value on the next cycle; rd_ptr toggles; bank_cnt decrements by 1.
REQ-038 SHALL cover: bank_cnt=1, wr_done and rd_done in the same cycle -> bank_cnt stays 1; both pointers toggle.
REQ-039 SHALL cover: rd_en and rd_done with rd_ready=0 -> rd_valid=0, rd_data=0, no state change.
REQ-040 SHALL cover: rst pulse with bank_cnt=2 and a read in flight -> the next cycle has rd_valid=0, bank_cnt=0, wr_ready=1.
